adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
Shares the single 32-bit word adder (carry-in; carry/zero/neg/overflow flags) between two requesters.
- Requester A is the execute-stage ALU and issues single-word adds.
- Requester B is the multiply-accumulate unit and issues single-word or 64-bit (long) adds. A long add is sequenced as two adder passes with the carry chained between them.
- Arbitration is round-robin. Results and flags are registered and returned with a one-cycle done pulse to the winning requester.

Parameters:
WIDTH, 32, adder word width; long operands/results are 2*WIDTH.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_ReqA  in  1  A request; held high until out_DoneA
in_LeftA  in  WIDTH  A left operand, held stable while requesting
in_RightA  in  WIDTH  A right operand
in_CarryA  in  1  A carry-in
in_ReqB  in  1  B request; held high until out_DoneB
in_LongB  in  1  1 = 64-bit add, 0 = single word; held with request
in_LeftB  in  2*WIDTH  B left operand (upper half ignored if !in_LongB)
in_RightB  in  2*WIDTH  B right operand
in_CarryB  in  1  B carry-in (into low word)
out_AdderLeft  out  WIDTH  left operand to word adder
out_AdderRight  out  WIDTH  right operand to word adder
out_AdderCarry  out  1  carry-in to word adder
in_AdderResult  in  WIDTH  adder sum
in_AdderCarry, in_AdderZero, in_AdderNeg, in_AdderOverflow  in  1 each  adder flags
out_DoneA  out  1  one-cycle pulse: A result valid
out_DoneB  out  1  one-cycle pulse: B result valid
out_Result  out  2*WIDTH  registered result (upper half 0 for single-word)
out_Carry, out_Zero, out_Neg, out_Overflow  out  1 each  registered flags
out_Busy  out  1  state != IDLE

Behaviour:
- States: IDLE, LOW, HIGH, DONE. Owner register (A/B), priority pointer, low-pass carry register.
- Reset (async, active low): state IDLE, priority A; out_Result 0; all flags 0; both done 0; out_Busy 0. This applies mid-operation too; the pending request is dropped with no done pulse.
- IDLE, arbitration:
  - Only A requesting: grant A.
  - Only B requesting: grant B.
  - Both requesting: grant the priority holder.
  - On grant: latch owner; priority flips to the other requester; go to LOW.
  - No request: stay in IDLE.
- LOW pass:
  - Adder inputs = owner's low words and owner's carry-in.
  - At the clock edge: register in_AdderResult into out_Result[WIDTH-1:0].
  - If owner is B and in_LongB: save in_AdderCarry and low-zero, then go to HIGH.
  - Otherwise: load all four flags, clear the upper half of out_Result, go to DONE.
- HIGH pass:
  - Adder inputs = B upper words, carry-in = saved low carry.
  - At the edge: register upper result.
  - Carry/Neg/Overflow come from the high pass.
  - Zero = saved low-zero AND in_AdderZero.
  - Go to DONE.
- DONE: the owner's done output is high for exactly this cycle; out_Result and flags are valid and hold until the next LOW/HIGH load. Next state is IDLE; no arbitration occurs in DONE.
- The requester must drop its request in the DONE cycle. A request still high in the following IDLE cycle is a new request.
- Adder drive in IDLE/DONE: operands 0, carry 0.
- Latency from request seen in IDLE to done:
  - Single-word add: 2 cycles.
  - Long add: 3 cycles.
- Fairness:
  - Back-to-back contention alternates A, B, A, ...
  - A lone requester may be granted repeatedly. Priority still flips after each grant.
- Wrap-around: sums are modulo 2^WIDTH (single) or 2^(2*WIDTH) (long). Carry-out of the top pass goes to out_Carry.

Test Plan:
- Only A: 0x00001011 + 0x10001010, cin 0 → out_DoneA 2 cycles after request; result 0x10002021; C=Z=N=V=0; out_DoneB never high.
- Overflow on A: 0x70001011 + 0x70001010 → 0xE0002021, N=1, V=1, C=0, Z=0.
- Contention: A and B request in the same IDLE cycle right after reset → A served first (DONE pulse). B is granted in the next IDLE; if both stay requesting, grants alternate A, B, A.
- Long B with chained carry: 0x00000000_FFFFFFFF + 0x00000000_00000001 → HIGH pass carry-in = 1; result 0x00000001_00000000; Z=0, C=0; out_DoneB 3 cycles after request.
- Long zero/carry: 0xFFFFFFFF_FFFFFFFF + 0x00000000_00000001 → result 0; Z=1, C=1, N=0, V=0. Also check single-word B (in_LongB=0) with 0xF0001011 + 0xF0001010 → 0xE0002021, C=1, N=1, upper half 0.
- Reset during HIGH of a long add → outputs immediately at reset values; no done pulse; priority = A. After release, B re-requests and completes correctly.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one word adder between the ALU (A) and the MAC (B).
// B may issue 2*WIDTH adds, sequenced as a low pass and a carry-chained high pass.
//
// Ports:
//   clock, reset                     rising-edge clock, async active-low reset
//   in_ReqA/in_LeftA/in_RightA/in_CarryA           A request and word operands
//   in_ReqB/in_LongB/in_LeftB/in_RightB/in_CarryB  B request, long select, operands
//   out_AdderLeft/out_AdderRight/out_AdderCarry    drive to the shared word adder
//   in_AdderResult/in_Adder{Carry,Zero,Neg,Overflow} sum and flags from the adder
//   out_DoneA/out_DoneB              one-cycle result-valid pulse to the winner
//   out_Result/out_{Carry,Zero,Neg,Overflow}  registered result and flags
//   out_Busy                         arbiter is not idle
module adder_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_ReqA,
  input  logic [WIDTH-1:0]   in_LeftA,
  input  logic [WIDTH-1:0]   in_RightA,
  input  logic               in_CarryA,
  input  logic               in_ReqB,
  input  logic               in_LongB,
  input  logic [2*WIDTH-1:0] in_LeftB,
  input  logic [2*WIDTH-1:0] in_RightB,
  input  logic               in_CarryB,
  output logic [WIDTH-1:0]   out_AdderLeft,
  output logic [WIDTH-1:0]   out_AdderRight,
  output logic               out_AdderCarry,
  input  logic [WIDTH-1:0]   in_AdderResult,
  input  logic               in_AdderCarry,
  input  logic               in_AdderZero,
  input  logic               in_AdderNeg,
  input  logic               in_AdderOverflow,
  output logic               out_DoneA,
  output logic               out_DoneB,
  output logic [2*WIDTH-1:0] out_Result,
  output logic               out_Carry,
  output logic               out_Zero,
  output logic               out_Neg,
  output logic               out_Overflow,
  output logic               out_Busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic owner_b;
  logic prio_b;
  logic grant_b;
  logic low_carry;
  logic low_zero;
  logic long_pass;

  assign long_pass = owner_b && in_LongB;

  always_comb begin
    state_nxt      = state;
    grant_b        = owner_b;
    out_AdderLeft  = '0;
    out_AdderRight = '0;
    out_AdderCarry = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_ReqA || in_ReqB) begin
          grant_b   = (in_ReqA && in_ReqB) ? prio_b : in_ReqB;
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (owner_b) begin
          out_AdderLeft  = in_LeftB[WIDTH-1:0];
          out_AdderRight = in_RightB[WIDTH-1:0];
          out_AdderCarry = in_CarryB;
        end else begin
          out_AdderLeft  = in_LeftA;
          out_AdderRight = in_RightA;
          out_AdderCarry = in_CarryA;
        end
        state_nxt = long_pass ? HIGH : DONE;
      end
      HIGH: begin
        out_AdderLeft  = in_LeftB[2*WIDTH-1:WIDTH];
        out_AdderRight = in_RightB[2*WIDTH-1:WIDTH];
        out_AdderCarry = low_carry;
        state_nxt      = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      owner_b      <= 1'b0;
      prio_b       <= 1'b0;
      low_carry    <= 1'b0;
      low_zero     <= 1'b0;
      out_Result   <= '0;
      out_Carry    <= 1'b0;
      out_Zero     <= 1'b0;
      out_Neg      <= 1'b0;
      out_Overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == LOW) begin
        owner_b <= grant_b;
        prio_b  <= !grant_b;
      end
      if (state == LOW) begin
        out_Result[WIDTH-1:0] <= in_AdderResult;
        if (long_pass) begin
          low_carry <= in_AdderCarry;
          low_zero  <= in_AdderZero;
        end else begin
          out_Result[2*WIDTH-1:WIDTH] <= '0;
          out_Carry    <= in_AdderCarry;
          out_Zero     <= in_AdderZero;
          out_Neg      <= in_AdderNeg;
          out_Overflow <= in_AdderOverflow;
        end
      end
      if (state == HIGH) begin
        out_Result[2*WIDTH-1:WIDTH] <= in_AdderResult;
        out_Carry    <= in_AdderCarry;
        out_Zero     <= low_zero && in_AdderZero;
        out_Neg      <= in_AdderNeg;
        out_Overflow <= in_AdderOverflow;
      end
    end
  end

  assign out_DoneA = (state == DONE) && !owner_b;
  assign out_DoneB = (state == DONE) && owner_b;
  assign out_Busy  = (state != IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized bench for adder_share_arbiter with a word-adder model
// and a transaction-level reference for arbitration, latency and sums.
module tb_adder_share_arbiter;

  localparam int W = 32;

  logic           clock = 1'b0;
  logic           reset;
  logic           in_ReqA;
  logic [W-1:0]   in_LeftA;
  logic [W-1:0]   in_RightA;
  logic           in_CarryA;
  logic           in_ReqB;
  logic           in_LongB;
  logic [2*W-1:0] in_LeftB;
  logic [2*W-1:0] in_RightB;
  logic           in_CarryB;
  logic [W-1:0]   out_AdderLeft;
  logic [W-1:0]   out_AdderRight;
  logic           out_AdderCarry;
  logic [W-1:0]   in_AdderResult;
  logic           in_AdderCarry;
  logic           in_AdderZero;
  logic           in_AdderNeg;
  logic           in_AdderOverflow;
  logic           out_DoneA;
  logic           out_DoneB;
  logic [2*W-1:0] out_Result;
  logic           out_Carry;
  logic           out_Zero;
  logic           out_Neg;
  logic           out_Overflow;
  logic           out_Busy;

  adder_share_arbiter #(.WIDTH(W)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_ReqA         (in_ReqA),
    .in_LeftA        (in_LeftA),
    .in_RightA       (in_RightA),
    .in_CarryA       (in_CarryA),
    .in_ReqB         (in_ReqB),
    .in_LongB        (in_LongB),
    .in_LeftB        (in_LeftB),
    .in_RightB       (in_RightB),
    .in_CarryB       (in_CarryB),
    .out_AdderLeft   (out_AdderLeft),
    .out_AdderRight  (out_AdderRight),
    .out_AdderCarry  (out_AdderCarry),
    .in_AdderResult  (in_AdderResult),
    .in_AdderCarry   (in_AdderCarry),
    .in_AdderZero    (in_AdderZero),
    .in_AdderNeg     (in_AdderNeg),
    .in_AdderOverflow(in_AdderOverflow),
    .out_DoneA       (out_DoneA),
    .out_DoneB       (out_DoneB),
    .out_Result      (out_Result),
    .out_Carry       (out_Carry),
    .out_Zero        (out_Zero),
    .out_Neg         (out_Neg),
    .out_Overflow    (out_Overflow),
    .out_Busy        (out_Busy)
  );

  always #5 clock = ~clock;

  logic [W:0] add_sum;
  assign add_sum = {1'b0, out_AdderLeft} + {1'b0, out_AdderRight}
                 + {{W{1'b0}}, out_AdderCarry};
  assign in_AdderResult   = add_sum[W-1:0];
  assign in_AdderCarry    = add_sum[W];
  assign in_AdderZero     = (add_sum[W-1:0] == '0);
  assign in_AdderNeg      = add_sum[W-1];
  assign in_AdderOverflow = (out_AdderLeft[W-1] == out_AdderRight[W-1])
                         && (add_sum[W-1] != out_AdderLeft[W-1]);

  int n_vec = 0;
  int n_bad = 0;
  bit prio_b = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd32();
    case ($urandom_range(0, 4))
      0:       rnd32 = '0;
      1:       rnd32 = '1;
      2:       rnd32 = 32'h8000_0000;
      3:       rnd32 = 32'h7fff_ffff;
      default: rnd32 = $urandom;
    endcase
  endfunction

  task automatic set_a(input logic [W-1:0] l, input logic [W-1:0] r,
                       input logic c);
    in_ReqA = 1'b1; in_LeftA = l; in_RightA = r; in_CarryA = c;
  endtask

  task automatic set_b(input logic lg, input logic [2*W-1:0] l,
                       input logic [2*W-1:0] r, input logic c);
    in_ReqB = 1'b1; in_LongB = lg; in_LeftB = l; in_RightB = r; in_CarryB = c;
  endtask

  // Called at a negedge with the DUT idle and at least one request raised.
  task automatic run_round();
    bit           win_b;
    int           lat;
    int           got;
    logic [64:0]  full;
    logic [63:0]  res;
    logic [63:0]  l;
    logic [63:0]  r;
    logic         cin;
    logic [3:0]   flg;
    win_b  = (in_ReqA && in_ReqB) ? prio_b : in_ReqB;
    prio_b = !win_b;
    if (win_b && in_LongB) begin
      lat = 3; l = in_LeftB; r = in_RightB; cin = in_CarryB;
      full = {1'b0, l} + {1'b0, r} + 65'(cin);
      res  = full[63:0];
      flg  = {full[64], res == 0, res[63], (l[63] == r[63]) && (res[63] != l[63])};
    end else begin
      lat = 2;
      l   = win_b ? {32'h0, in_LeftB[31:0]}  : {32'h0, in_LeftA};
      r   = win_b ? {32'h0, in_RightB[31:0]} : {32'h0, in_RightA};
      cin = win_b ? in_CarryB : in_CarryA;
      full = 65'(l) + 65'(r) + 65'(cin);
      res  = {32'h0, full[31:0]};
      flg  = {full[32], res == 0, res[31], (l[31] == r[31]) && (res[31] != l[31])};
    end
    got = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      chk("busy", 64'(out_Busy), 64'd1);
      if (out_DoneA || out_DoneB) begin
        got = c;
        break;
      end
    end
    chk("latency", 64'(got), 64'(lat));
    chk("doneA", 64'(out_DoneA), 64'(!win_b));
    chk("doneB", 64'(out_DoneB), 64'(win_b));
    chk("result", out_Result, res);
    chk("flags_CZNV", 64'({out_Carry, out_Zero, out_Neg, out_Overflow}), 64'(flg));
    if (win_b) in_ReqB = 1'b0;
    else       in_ReqA = 1'b0;
    @(negedge clock);
    chk("idle_busy", 64'(out_Busy), 64'd0);
    chk("idle_done", 64'({out_DoneA, out_DoneB}), 64'd0);
    chk("result_hold", out_Result, res);
  endtask

  initial begin
    reset = 1'b0;
    in_ReqA = 0; in_LeftA = 0; in_RightA = 0; in_CarryA = 0;
    in_ReqB = 0; in_LongB = 0; in_LeftB = 0; in_RightB = 0; in_CarryB = 0;
    repeat (2) @(negedge clock);
    chk("rst_outs", 64'({out_DoneA, out_DoneB, out_Busy, out_Carry,
                         out_Zero, out_Neg, out_Overflow}), 64'd0);
    chk("rst_result", out_Result, 64'd0);
    reset = 1'b1;
    @(negedge clock);

    set_a(32'h0000_1011, 32'h1000_1010, 1'b0);
    set_b(1'b0, 64'hdead_beef_f000_1011, 64'h1234_5678_f000_1010, 1'b0);
    run_round();
    set_a(32'h7000_1011, 32'h7000_1010, 1'b0);
    run_round();
    run_round();

    set_b(1'b1, 64'h0000_0000_ffff_ffff, 64'h0000_0000_0000_0001, 1'b0);
    run_round();
    set_b(1'b1, 64'hffff_ffff_ffff_ffff, 64'h0000_0000_0000_0001, 1'b0);
    run_round();
    set_a(32'h0000_1011, 32'h1000_1010, 1'b0);
    run_round();

    set_b(1'b1, 64'h8000_0000_ffff_ffff, 64'h8000_0000_0000_0001, 1'b1);
    @(negedge clock);
    @(negedge clock);
    chk("mid_busy", 64'(out_Busy), 64'd1);
    reset = 1'b0;
    in_ReqB = 1'b0;
    #1;
    chk("mid_rst_outs", 64'({out_DoneA, out_DoneB, out_Busy, out_Carry,
                             out_Zero, out_Neg, out_Overflow}), 64'd0);
    chk("mid_rst_result", out_Result, 64'd0);
    prio_b = 1'b0;
    @(negedge clock);
    chk("rst_no_done", 64'({out_DoneA, out_DoneB}), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    set_a(32'hffff_ffff, 32'h0000_0000, 1'b1);
    set_b(1'b1, 64'h8000_0000_ffff_ffff, 64'h8000_0000_0000_0001, 1'b1);
    run_round();
    run_round();

    for (int i = 0; i < 300; i++) begin
      if (!in_ReqA && $urandom_range(0, 1) == 1)
        set_a(rnd32(), rnd32(), 1'($urandom_range(0, 1)));
      if (!in_ReqB && $urandom_range(0, 1) == 1)
        set_b(1'($urandom_range(0, 1)), {rnd32(), rnd32()},
              {rnd32(), rnd32()}, 1'($urandom_range(0, 1)));
      if (!in_ReqA && !in_ReqB) begin
        @(negedge clock);
        chk("idle_stay", 64'(out_Busy), 64'd0);
      end else begin
        run_round();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
